fc_seq_ctrl: RTL and testbench
==============================

Name: fc_seq_ctrl

Overview:
Sequencer for one fully-connected layer built from per-neuron combinational dot-product/ReLU trees. Each tree is a layer-style block with constant weights, 128 inputs, and one ReLU output.
- Collects the IN-element activation vector from an upstream valid/ready stream into a register buffer.
- Drives the shared x vector and a neuron-select index to the neuron bank.
- Waits a programmable settle time for the adder tree, then samples each neuron result in turn.
- Streams the OUT results downstream as a valid/ready stream.

Parameters:
WIDTH, 8, activation bit width
IN, 128, input vector length
OUT, 10, number of neurons (outputs) in the layer
SETTLE, 2, cycles held after nsel changes before z is sampled (minimum 1)
OW, 2*WIDTH+$clog2(IN), neuron result width (23 at defaults)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream activation valid
in_ready  out  1  block accepts an activation
in_data  in  WIDTH  activation, element order 0..IN-1
in_last  in  1  upstream marks final element
x_vec  out  IN*WIDTH  buffered vector; element i at bits [i*WIDTH +: WIDTH]
nsel  out  $clog2(OUT)  neuron index presented to the neuron bank
z_in  in  OW  combinational result of the selected neuron
out_valid  out  1  result valid
out_ready  in  1  downstream accepts a result
out_data  out  OW  sampled neuron result
out_idx  out  $clog2(OUT)  neuron index of out_data
out_last  out  1  high with result OUT-1
busy  out  1  high in every state except LOAD
err  out  1  sticky framing error

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-low.
  - On reset: state=LOAD, wr_cnt=0, nsel=0, settle_cnt=0, x buffer=0.
  - All outputs reset to 0, except in_ready=1.
- State LOAD:
  - in_ready=1.
  - Each in_valid&&in_ready: write buf[wr_cnt]=in_data, then wr_cnt++.
  - On the accept with wr_cnt==IN-1: wr_cnt->0, nsel->0, settle_cnt->0, go to EVAL. in_ready drops the next cycle.
  - in_last high on an accept where wr_cnt!=IN-1 sets err. Load continues purely on count.
  - Missing in_last on element IN-1 also sets err.
  - Transfer completes on count regardless of err.
- State EVAL:
  - in_ready=0. x_vec holds steady.
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE-1: register out_data=z_in, out_idx=nsel, out_last=(nsel==OUT-1), out_valid=1; go to EMIT.
- State EMIT:
  - Hold out_valid and all out_* stable until out_ready.
  - On out_valid&&out_ready:
    - if nsel==OUT-1: out_valid->0, wr_cnt->0, go to LOAD.
    - else: nsel++, settle_cnt->0, out_valid->0, go to EVAL.
- Latency:
  - Last input accept to first out_valid: SETTLE+1 cycles.
  - With out_ready held high, one result every SETTLE+1 cycles.
  - Total per vector: IN + OUT*(SETTLE+1) cycles minimum.
- Backpressure: out_ready low stalls indefinitely in EMIT. nsel and x_vec stay stable throughout the stall.
- No overlap: the next vector is not accepted until the last result handshakes (single buffer).
- Reset mid-operation: abort immediately. Partial vector and pending result are discarded. err clears.
- Arithmetic: z_in is already ReLU'd (non-negative, MSB 0). Pass through unmodified, no truncation.
- err stays set until reset.

Optional Feature:
FC_ARGMAX_EN
- Defined: adds outputs cls (width $clog2(OUT)) and cls_valid (1).
- Tracks running max over sampled results; strict greater-than, so ties keep the lower index.
- Max register resets to 0/index 0 at each EVAL entry with nsel==0.
- cls_valid pulses for one cycle on the out_last handshake, with cls = winning index.
- Undefined: ports and logic absent; all other behaviour is identical.

Test Plan:
- Reset check: assert rst_n=0 mid-stream -> in_ready=1, out_valid=0, busy=0, err=0, x_vec=0 while reset is held.
- Basic vector: stream 128 elements, in_data=i[7:0], in_last on element 127; bench model returns z_in=nsel*100 -> 10 results 0,100,...,900, out_idx 0..9, out_last only on idx 9. First out_valid lands 3 cycles after the final accept (SETTLE=2).
- Backpressure: out_ready low for 20 cycles on result 4 -> out_data=400 and nsel=4 held stable; result 5 follows SETTLE+1 cycles after the release.
- Upstream gaps: in_valid toggled 1/0 every cycle -> x_vec identical to the gap-free case; EVAL entered only after the 128th accept.
- Framing error: in_last on element 63 -> err=1, load still takes 128 elements, results still produced. A second vector with correct in_last leaves err=1.
- FC_ARGMAX_EN: model results {5,9,9,2,...} -> cls=1; cls_valid pulses once, exactly on the handshake with out_idx=9.

Source files
------------

// File: rtl/fc_seq_ctrl.sv
// fc_seq_ctrl - sequencer for one fully-connected layer.
//
// Collects an IN-element activation vector from an upstream valid/ready
// stream into a register buffer, presents it in parallel (x_vec) to a bank
// of combinational dot-product/ReLU neurons, walks the neuron select (nsel)
// through 0..OUT-1, waits SETTLE cycles per neuron for the adder tree to
// settle, samples z_in and streams the results downstream.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream activation handshake
//   in_data, in_last    activation element (order 0..IN-1), end-of-vector mark
//   x_vec               buffered vector, element i at [i*WIDTH +: WIDTH]
//   nsel                neuron index presented to the neuron bank
//   z_in                combinational (already ReLU'd) result of neuron nsel
//   out_valid/out_ready downstream result handshake
//   out_data, out_idx   sampled neuron result and its neuron index
//   out_last            high with result OUT-1
//   busy                high whenever not loading
//   err                 sticky framing error (in_last misplaced or missing)
//
// Optional build macro FC_ARGMAX_EN adds cls/cls_valid: the index of the
// largest result of the vector (ties keep the lower index), flagged for one
// cycle on the handshake of the last result.

module fc_seq_ctrl #(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int OUT    = 10,
  parameter int SETTLE = 2,
  parameter int OW     = 2*WIDTH + $clog2(IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_last,
  output logic [IN*WIDTH-1:0]     x_vec,
  output logic [$clog2(OUT)-1:0]  nsel,
  input  logic [OW-1:0]           z_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OW-1:0]           out_data,
  output logic [$clog2(OUT)-1:0]  out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err
`ifdef FC_ARGMAX_EN
  ,
  output logic [$clog2(OUT)-1:0]  cls,
  output logic                    cls_valid
`endif
);

  localparam int CW = $clog2(IN);
  localparam int NW = $clog2(OUT);
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [CW-1:0] LAST_WR     = CW'(IN - 1);
  localparam logic [NW-1:0] LAST_N      = NW'(OUT - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {LOAD, EVAL, EMIT} state_t;

  state_t          state_reg;
  logic [CW-1:0]   wr_cnt_reg;
  logic [NW-1:0]   nsel_reg;
  logic [SW-1:0]   settle_cnt_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic [OW-1:0]   out_data_reg;
  logic [NW-1:0]   out_idx_reg;
  logic            out_last_reg;
  logic            busy_reg;
  logic            err_reg;
`ifdef FC_ARGMAX_EN
  logic [OW-1:0]   max_val_reg;
  logic [NW-1:0]   max_idx_reg;
`endif

  // in_ready_reg is only ever high in LOAD, so this is the accept strobe.
  logic load_en;
  assign load_en = in_valid & in_ready_reg;

  // Activation buffer: one register per element so the whole vector is
  // visible to the neuron bank at once. Written only while loading, so
  // x_vec is frozen during EVAL/EMIT.
  genvar gi;
  for (gi = 0; gi < IN; gi++) begin : g_buf
    logic [WIDTH-1:0] elem_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        elem_reg <= '0;
      end else if (load_en && (wr_cnt_reg == CW'(gi))) begin
        elem_reg <= in_data;
      end
    end
    assign x_vec[gi*WIDTH +: WIDTH] = elem_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= LOAD;
      wr_cnt_reg     <= '0;
      nsel_reg       <= '0;
      settle_cnt_reg <= '0;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_idx_reg    <= '0;
      out_last_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
`ifdef FC_ARGMAX_EN
      max_val_reg    <= '0;
      max_idx_reg    <= '0;
`endif
    end else begin
      case (state_reg)
        LOAD: begin
          if (load_en) begin
            if (wr_cnt_reg == LAST_WR) begin
              // Final element: the load ends on count, in_last only
              // feeds the framing check.
              if (!in_last) err_reg <= 1'b1;
              wr_cnt_reg     <= '0;
              nsel_reg       <= '0;
              settle_cnt_reg <= '0;
              in_ready_reg   <= 1'b0;
              busy_reg       <= 1'b1;
              state_reg      <= EVAL;
`ifdef FC_ARGMAX_EN
              max_val_reg    <= '0;
              max_idx_reg    <= '0;
`endif
            end else begin
              if (in_last) err_reg <= 1'b1;
              wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
          end
        end

        EVAL: begin
          // nsel has been stable for SETTLE cycles when the count
          // reaches SETTLE-1, so z_in is sampled on that edge.
          if (settle_cnt_reg == SETTLE_LAST) begin
            out_data_reg  <= z_in;
            out_idx_reg   <= nsel_reg;
            out_last_reg  <= (nsel_reg == LAST_N);
            out_valid_reg <= 1'b1;
            state_reg     <= EMIT;
`ifdef FC_ARGMAX_EN
            // Strict compare: on a tie the earlier (lower) index wins.
            if (z_in > max_val_reg) begin
              max_val_reg <= z_in;
              max_idx_reg <= nsel_reg;
            end
`endif
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end

        EMIT: begin
          // out_valid is always high here, out_ready alone completes it.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            if (nsel_reg == LAST_N) begin
              wr_cnt_reg   <= '0;
              in_ready_reg <= 1'b1;
              busy_reg     <= 1'b0;
              state_reg    <= LOAD;
            end else begin
              nsel_reg       <= nsel_reg + 1'b1;
              settle_cnt_reg <= '0;
              state_reg      <= EVAL;
            end
          end
        end

        default: begin
          state_reg    <= LOAD;
          in_ready_reg <= 1'b1;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign nsel      = nsel_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_idx   = out_idx_reg;
  assign out_last  = out_last_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;

`ifdef FC_ARGMAX_EN
  // Running max is final once the last result has been sampled, so the
  // flag can coincide with the handshake of that result.
  assign cls       = max_idx_reg;
  assign cls_valid = out_valid_reg & out_ready & out_last_reg;
`endif

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Testbench for fc_seq_ctrl: a table of vector scenarios (basic, backpressure,
// upstream gaps, framing error, sticky error), a mid-stream reset sequence,
// randomized vectors against a dot-product neuron model, and the optional
// argmax output when FC_ARGMAX_EN is defined.

module tb_fc_seq_ctrl;

  localparam int WIDTH  = 8;
  localparam int IN     = 128;
  localparam int OUT    = 10;
  localparam int SETTLE = 2;
  localparam int OW     = 2*WIDTH + $clog2(IN);
  localparam int NW     = $clog2(OUT);

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic                in_last;
  logic [IN*WIDTH-1:0] x_vec;
  logic [NW-1:0]       nsel;
  logic [OW-1:0]       z_in;
  logic                out_valid;
  logic                out_ready;
  logic [OW-1:0]       out_data;
  logic [NW-1:0]       out_idx;
  logic                out_last;
  logic                busy;
  logic                err;
`ifdef FC_ARGMAX_EN
  logic [NW-1:0]       cls;
  logic                cls_valid;
`endif

  always #5 clk = ~clk;

  fc_seq_ctrl #(
    .WIDTH(WIDTH), .IN(IN), .OUT(OUT), .SETTLE(SETTLE), .OW(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .x_vec(x_vec), .nsel(nsel), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .err(err)
`ifdef FC_ARGMAX_EN
    , .cls(cls), .cls_valid(cls_valid)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int               zmode = 0;
  logic [OW-1:0]    ztab [16];
  logic [WIDTH-1:0] vdat [IN];
  bit               exp_err = 1'b0;

  // ---------------- neuron bank model ----------------
  // Each neuron: signed small weights derived from (element, neuron), ReLU.
  function automatic logic [OW-1:0] neuron(input logic [IN*WIDTH-1:0] xv, input int n);
    int acc;
    acc = 0;
    for (int i = 0; i < IN; i++)
      acc += int'(xv[i*WIDTH +: WIDTH]) * (((i*3 + n*5) % 7) - 3);
    if (acc < 0) acc = 0;
    return OW'(acc);
  endfunction

  always_comb begin
    case (zmode)
      0:       z_in = OW'(int'(nsel) * 100);
      1:       z_in = ztab[nsel];
      default: z_in = neuron(x_vec, int'(nsel));
    endcase
  end

  function automatic logic [IN*WIDTH-1:0] pack_vdat();
    logic [IN*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < IN; i++) v[i*WIDTH +: WIDTH] = vdat[i];
    return v;
  endfunction

  function automatic logic [OW-1:0] exp_res(input int k);
    case (zmode)
      0:       return OW'(k * 100);
      1:       return ztab[k];
      default: return neuron(pack_vdat(), k);
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

`ifdef FC_ARGMAX_EN
  int            pulses = 0;
  int            pulse_idx = 0;
  logic          pulse_hs = 1'b0;
  logic [NW-1:0] pulse_cls = '0;
  always @(negedge clk) begin
    if (cls_valid === 1'b1) begin
      pulses    <= pulses + 1;
      pulse_idx <= int'(out_idx);
      pulse_hs  <= out_valid & out_ready;
      pulse_cls <= cls;
    end
  end
`endif

  // Streams vdat; gap: 0 none, 1 toggle every cycle, 2 random.
  // acc_cyc returns the cycle in which the final element was driven.
  task automatic send(input int tag, input int last_pos, input int gap, output int acc_cyc);
    int i, g;
    bit tog, early, hs;
    i = 0; g = 0; tog = 1'b1; early = 1'b0; acc_cyc = cyc;
    while (i < IN && g < 4*IN) begin
      case (gap)
        0: in_valid = 1'b1;
        1: begin in_valid = tog; tog = ~tog; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = vdat[i];
      in_last = (i == last_pos);
      if (in_ready !== 1'b1) early = 1'b1;
      hs = in_valid && (in_ready === 1'b1);
      if (hs) acc_cyc = cyc;
      tick();
      g++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk($sformatf("v%0d accepted count", tag), 64'(i), 64'(IN));
    chk($sformatf("v%0d in_ready dropped early", tag), 64'(early), 64'(0));
    chk($sformatf("v%0d in_ready after load", tag), 64'(in_ready), 64'(0));
    chk($sformatf("v%0d busy after load", tag), 64'(busy), 64'(1));
    chk($sformatf("v%0d x_vec match", tag), 64'(x_vec === pack_vdat()), 64'(1));
    chk($sformatf("v%0d err after load", tag), 64'(err), 64'(exp_err));
  endtask

  // Collects OUT results; stalls result stall_idx for stall_len cycles,
  // optionally adds random stalls elsewhere.
  task automatic collect(input int tag, input int stall_idx, input int stall_len,
                         input bit rand_ready, input int ref_cyc);
    int prev, w, st;
    bit bad;
    logic [OW-1:0]       ev, hd;
    logic [NW-1:0]       hn, hi;
    logic [IN*WIDTH-1:0] hx;
    prev = ref_cyc;
    for (int k = 0; k < OUT; k++) begin
      w = 0;
      while (out_valid !== 1'b1 && w < 100) begin tick(); w++; end
      if (out_valid !== 1'b1) begin
        chk($sformatf("v%0d out_valid timeout k=%0d", tag, k), 64'(0), 64'(1));
        return;
      end
      ev = exp_res(k);
      chk($sformatf("v%0d k=%0d latency", tag, k), 64'(cyc - prev), 64'(SETTLE + 1));
      chk($sformatf("v%0d k=%0d out_data", tag, k), 64'(out_data), 64'(ev));
      chk($sformatf("v%0d k=%0d out_idx", tag, k), 64'(out_idx), 64'(k));
      chk($sformatf("v%0d k=%0d out_last", tag, k), 64'(out_last), 64'(k == OUT-1));
      chk($sformatf("v%0d k=%0d nsel", tag, k), 64'(nsel), 64'(k));
      chk($sformatf("v%0d k=%0d busy/in_ready", tag, k), 64'({busy, in_ready}), 64'(2));
      st = (k == stall_idx) ? stall_len : (rand_ready ? int'($urandom_range(0, 3)) : 0);
      out_ready = 1'b0;
      if (st > 0) begin
        hd = out_data; hn = nsel; hi = out_idx; hx = x_vec; bad = 1'b0;
        for (int s = 0; s < st; s++) begin
          tick();
          if (out_valid !== 1'b1 || out_data !== hd || nsel !== hn ||
              out_idx !== hi || x_vec !== hx) bad = 1'b1;
        end
        chk($sformatf("v%0d k=%0d stall hold", tag, k), 64'(bad), 64'(0));
      end
      out_ready = 1'b1;
      prev = cyc;
      tick();
      out_ready = 1'b0;
    end
    chk($sformatf("v%0d end out_valid", tag), 64'(out_valid), 64'(0));
    chk($sformatf("v%0d end busy", tag), 64'(busy), 64'(0));
    chk($sformatf("v%0d end in_ready", tag), 64'(in_ready), 64'(1));
  endtask

  // ---------------- scenario table ----------------
  typedef struct {
    int last_pos;
    int gap;
    int stall_idx;
    int stall_len;
    int zm;
    bit exp_err;
  } rec_t;

  rec_t tbl [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) ztab[i] = '0;

    //            last_pos gap stall_idx stall_len zmode exp_err
    tbl[0] = '{IN-1, 0, -1, 0,  0, 1'b0};   // basic vector
    tbl[1] = '{IN-1, 0,  4, 20, 0, 1'b0};   // backpressure on result 4
    tbl[2] = '{IN-1, 1, -1, 0,  0, 1'b0};   // upstream gaps
    tbl[3] = '{63,   0, -1, 0,  0, 1'b1};   // in_last on element 63
    tbl[4] = '{IN-1, 0, -1, 0,  0, 1'b1};   // clean vector, err sticky

    // Reset state while held
    tick(); tick(); tick();
    chk("rst in_ready", 64'(in_ready), 64'(1));
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst err", 64'(err), 64'(0));
    chk("rst x_vec zero", 64'(x_vec === '0), 64'(1));
    chk("rst nsel", 64'(nsel), 64'(0));
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < IN; i++) vdat[i] = WIDTH'(i);
      zmode   = tbl[t].zm;
      exp_err = tbl[t].exp_err;
      send(t, tbl[t].last_pos, tbl[t].gap, acc);
      collect(t, tbl[t].stall_idx, tbl[t].stall_len, 1'b0, acc);
      chk($sformatf("v%0d err after results", t), 64'(err), 64'(tbl[t].exp_err));
      tick();
    end

    // Mid-stream reset: partial vector in flight, err currently set.
    in_valid = 1'b1; in_data = 8'hA5;
    for (int i = 0; i < 50; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready", 64'(in_ready), 64'(1));
    chk("midrst out_valid", 64'(out_valid), 64'(0));
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst err", 64'(err), 64'(0));
    chk("midrst x_vec zero", 64'(x_vec === '0), 64'(1));
    tick(); tick();
    chk("midrst held x_vec zero", 64'(x_vec === '0), 64'(1));
    in_valid = 1'b0;
    rst_n = 1'b1;
    exp_err = 1'b0;
    tick();

    // Random vectors against the neuron model
    zmode = 2;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < IN; i++) vdat[i] = WIDTH'($urandom);
      send(10 + r, IN-1, (r == 0) ? 0 : 2, acc);
      collect(10 + r, -1, 0, (r != 0), acc);
    end

`ifdef FC_ARGMAX_EN
    begin
      int p0;
      zmode = 1;
      ztab[0] = 5; ztab[1] = 9; ztab[2] = 9; ztab[3] = 2; ztab[4] = 0;
      ztab[5] = 1; ztab[6] = 3; ztab[7] = 4; ztab[8] = 8; ztab[9] = 7;
      p0 = pulses;
      send(20, IN-1, 0, acc);
      collect(20, -1, 0, 1'b1, acc);
      tick();
      chk("argmax pulse count", 64'(pulses - p0), 64'(1));
      chk("argmax pulse idx", 64'(pulse_idx), 64'(9));
      chk("argmax pulse on handshake", 64'(pulse_hs), 64'(1));
      chk("argmax cls", 64'(pulse_cls), 64'(1));

      ztab[0] = 3; ztab[1] = 1; ztab[2] = 0; ztab[3] = 2; ztab[4] = 0;
      ztab[5] = 3; ztab[6] = 1; ztab[7] = 0; ztab[8] = 2; ztab[9] = 3;
      p0 = pulses;
      send(21, IN-1, 0, acc);
      collect(21, -1, 0, 1'b0, acc);
      tick();
      chk("argmax2 pulse count", 64'(pulses - p0), 64'(1));
      chk("argmax2 cls", 64'(pulse_cls), 64'(0));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
